pre_decode_queue: RTL

Parametrised instruction buffer between fetch and decode, replacing the single-register pre-decode pipeline stage. It accepts up to FETCH_WIDTH fetched instruction slots per cycle, including holes in the valid mask, and compacts them in program order into a circular buffer of DEPTH entries. It presents the oldest up to DECODE_WIDTH entries to the decoder each cycle. Fetch/decode width mismatch and decode stalls are absorbed without bubbles; a clear flushes all contents.

---
 rtl/pre_decode_queue.sv | 66 ++++++
 1 files changed

// File: rtl/pre_decode_queue.sv
// pre_decode_queue: compacting circular instruction buffer between fetch and decode
module pre_decode_queue #(
  parameter int FETCH_WIDTH   = 2,
  parameter int DECODE_WIDTH  = 2,
  parameter int DEPTH         = 8,
  parameter int PAYLOAD_WIDTH = 96,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  stall,
  input  logic [FETCH_WIDTH-1:0]                in_valid,
  input  logic [FETCH_WIDTH*PAYLOAD_WIDTH-1:0]  in_payload,
  output logic                                  in_ready,
  output logic [DECODE_WIDTH-1:0]               out_valid,
  output logic [DECODE_WIDTH*PAYLOAD_WIDTH-1:0] out_payload,
  output logic [CW-1:0]                         count,
  output logic                                  empty
);
  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW-1:0] off [FETCH_WIDTH];
  logic [CW-1:0] enq_cnt, enq_num, deq_num;
  logic enq;
  assign in_ready = int'(count) <= DEPTH - FETCH_WIDTH;
  assign empty = count == '0;
  assign enq = in_ready && |in_valid && !clear;
  assign enq_num = enq ? enq_cnt : '0;
  assign deq_num = (stall || clear) ? '0 : (count < CW'(DECODE_WIDTH) ? count : CW'(DECODE_WIDTH));
  // prefix popcount: slot i lands at tail plus the number of valid slots below it
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      off[i] = enq_cnt[AW-1:0];
      enq_cnt = enq_cnt + CW'(in_valid[i]);
    end
  end
  // lanes present the oldest entries as a contiguous prefix
  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    assign out_valid[g] = rst && !stall && !clear && (count > CW'(g));
    assign out_payload[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[head + AW'(g)];
  end
  // storage write of compacted valid slots; contents are not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (enq && in_valid[i]) mem[tail + off[i]] <= in_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end
  // pointer and occupancy update; clear and reset discard everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + enq_num[AW-1:0];
      head  <= head + deq_num[AW-1:0];
      count <= count + enq_num - deq_num;
    end
  end
endmodule
